// File: rtl/hcsr04_sensor_ctrl.sv
// HC-SR04 ultrasonic ranger controller: issues the trigger pulse, times the echo
// and converts the echo width to millimetres by counting clocks per mm.
module hcsr04_sensor_ctrl #(
   parameter int unsigned TRIG_CYCLES   = 500,
   parameter int unsigned CYCLES_PER_MM = 294,
   parameter int unsigned ECHO_WAIT_MAX = 1_500_000,
   parameter int unsigned ECHO_HIGH_MAX = 1_900_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        trigger,
   input  logic        echo,
   output logic        done,
   output logic [15:0] distance
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_TRIG      = 3'd1;
   localparam logic [2:0] S_WAIT_ECHO = 3'd2;
   localparam logic [2:0] S_MEASURE   = 3'd3;
   localparam logic [2:0] S_DONE      = 3'd4;

   localparam int unsigned TMR_MAX_A = (TRIG_CYCLES > ECHO_WAIT_MAX) ? TRIG_CYCLES : ECHO_WAIT_MAX;
   localparam int unsigned TMR_MAX   = (TMR_MAX_A > ECHO_HIGH_MAX) ? TMR_MAX_A : ECHO_HIGH_MAX;
   localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam int unsigned CYC_W     = (CYCLES_PER_MM > 1) ? $clog2(CYCLES_PER_MM) : 1;

   localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
   localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(ECHO_WAIT_MAX - 1);
   localparam logic [TMR_W-1:0] HIGH_LAST = TMR_W'(ECHO_HIGH_MAX - 1);
   localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CYCLES_PER_MM - 1);
   localparam logic [CYC_W-1:0] CYC_HALF  = CYC_W'(CYCLES_PER_MM / 2);

   logic [2:0]       state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [CYC_W-1:0] cyc_q,   cyc_d;
   logic [15:0]      mm_q,    mm_d;
   logic [15:0]      dist_q,  dist_d;
   logic             trig_q,  trig_d;
   logic             done_q,  done_d;
   logic             echo_s1_q, echo_s2_q, echo_prev_q;
   logic             echo_rise;
   logic [15:0]      mm_rounded;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_s1_q   <= 1'b0;
         echo_s2_q   <= 1'b0;
         echo_prev_q <= 1'b0;
      end else begin
         echo_s1_q   <= echo;
         echo_s2_q   <= echo_s1_q;
         echo_prev_q <= echo_s2_q;
      end
   end

   assign echo_rise = echo_s2_q & ~echo_prev_q;

   // Round half-up on the residual cycle count, without overflowing past 16'hFFFF.
   assign mm_rounded = ((cyc_q >= CYC_HALF) && (mm_q != 16'hFFFF)) ? (mm_q + 16'd1) : mm_q;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      cyc_d   = cyc_q;
      mm_d    = mm_q;
      dist_d  = dist_q;
      trig_d  = trig_q;
      done_d  = done_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_TRIG;
               trig_d  = 1'b1;
               done_d  = 1'b0;
               timer_d = '0;
            end
         end
         S_TRIG: begin
            if (timer_q == TRIG_LAST) begin
               trig_d  = 1'b0;
               timer_d = '0;
               state_d = S_WAIT_ECHO;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_WAIT_ECHO: begin
            if (echo_rise) begin
               state_d = S_MEASURE;
               timer_d = '0;
               cyc_d   = '0;
               mm_d    = '0;
            end else if (timer_q == WAIT_LAST) begin
               dist_d  = 16'hFFFF;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_MEASURE: begin
            if (!echo_s2_q) begin
               dist_d  = mm_rounded;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (timer_q == HIGH_LAST) begin
               dist_d  = 16'hFFFF;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
               if (cyc_q == CYC_LAST) begin
                  cyc_d = '0;
                  if (mm_q != 16'hFFFF) begin
                     mm_d = mm_q + 16'd1;
                  end
               end else begin
                  cyc_d = cyc_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            trig_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         cyc_q   <= '0;
         mm_q    <= '0;
         dist_q  <= '0;
         trig_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         cyc_q   <= cyc_d;
         mm_q    <= mm_d;
         dist_q  <= dist_d;
         trig_q  <= trig_d;
         done_q  <= done_d;
      end
   end

   assign trigger  = trig_q;
   assign done     = done_q;
   assign distance = dist_q;

endmodule

// File: tb/tb_hcsr04_sensor_ctrl.sv
// Directed bench for hcsr04_sensor_ctrl with shortened trigger/timeout parameters
// so every scenario, including both timeouts, runs in a few tens of thousands of clocks.
module tb_hcsr04_sensor_ctrl;

   localparam int unsigned TRIG    = 20;
   localparam int unsigned CPM     = 294;
   localparam int unsigned WAITMAX = 1000;
   localparam int unsigned HIGHMAX = 6000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        echo;
   logic        trigger;
   logic        done;
   logic [15:0] distance;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   hcsr04_sensor_ctrl #(
      .TRIG_CYCLES  (TRIG),
      .CYCLES_PER_MM(CPM),
      .ECHO_WAIT_MAX(WAITMAX),
      .ECHO_HIGH_MAX(HIGHMAX)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .trigger (trigger),
      .echo    (echo),
      .done    (done),
      .distance(distance)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Single-cycle start, then trigger width checked edge by edge; optional echo glitch inside TRIG.
   task automatic do_start(input logic [15:0] old_dist, input bit glitch);
      start = 1'b1;
      step(1);
      start = 1'b0;
      check("trig_rise", 16'(trigger), 16'd1);
      check("done_clr", 16'(done), 16'd0);
      check("dist_hold", distance, old_dist);
      if (glitch) echo = 1'b1;
      for (int unsigned k = 1; k < TRIG; k++) begin
         step(1);
         if (k == 3) echo = 1'b0;
         check("trig_high", 16'(trigger), 16'd1);
         check("done_low", 16'(done), 16'd0);
      end
      step(1);
      check("trig_fall", 16'(trigger), 16'd0);
   endtask

   // Echo high for w sampled clocks; done must rise on the third edge after echo drops.
   task automatic measure(input int unsigned w, input int unsigned start_at,
                          input logic [15:0] exp_dist, input string tag);
      step(5);
      echo = 1'b1;
      for (int unsigned i = 1; i <= w; i++) begin
         step(1);
         start = (i == start_at);
      end
      echo  = 1'b0;
      start = 1'b0;
      step(2);
      check({tag, "_pre"}, 16'(done), 16'd0);
      step(1);
      check({tag, "_done"}, 16'(done), 16'd1);
      check(tag, distance, exp_dist);
      check({tag, "_trig"}, 16'(trigger), 16'd0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      echo  = 1'b0;
      #25;
      check("rst_trig", 16'(trigger), 16'd0);
      check("rst_done", 16'(done), 16'd0);
      check("rst_dist", distance, 16'd0);
      #20 rst = 1'b0;
      step(2);

      do_start(16'd0, 1'b0);
      measure(5880, 0, 16'd20, "d20");
      step(50);
      check("done_hold", 16'(done), 16'd1);
      check("dist_idle", distance, 16'd20);

      do_start(16'd20, 1'b0);
      measure(1470, 0, 16'd5, "d5");
      step(50);
      do_start(16'd5, 1'b0);
      measure(2940, 0, 16'd10, "d10");

      do_start(16'd10, 1'b0);
      measure(1023, 0, 16'd3, "rnd_dn");
      do_start(16'd3, 1'b0);
      measure(1033, 0, 16'd4, "rnd_up");

      do_start(16'd4, 1'b0);
      measure(2938, 0, 16'd10, "jit_m");
      do_start(16'd10, 1'b0);
      measure(2942, 0, 16'd10, "jit_p");

      do_start(16'd10, 1'b0);
      measure(1, 0, 16'd0, "w1");

      do_start(16'd0, 1'b1);
      measure(2940, 0, 16'd10, "trig_glitch");

      do_start(16'd10, 1'b0);
      measure(2940, 1000, 16'd10, "start_in_meas");

      // No echo at all: wait timeout counted from the trigger falling edge.
      do_start(16'd10, 1'b0);
      step(WAITMAX - 1);
      check("noecho_pre", 16'(done), 16'd0);
      step(1);
      check("noecho_done", 16'(done), 16'd1);
      check("noecho_dist", distance, 16'hFFFF);

      do_start(16'hFFFF, 1'b0);
      echo = 1'b1;
      step(HIGHMAX - 10);
      check("stuck_pre", 16'(done), 16'd0);
      step(20);
      check("stuck_done", 16'(done), 16'd1);
      check("stuck_dist", distance, 16'hFFFF);
      echo = 1'b0;
      step(5);
      check("stuck_hold", 16'(done), 16'd1);

      // Asynchronous reset in the middle of a measurement.
      do_start(16'hFFFF, 1'b0);
      step(5);
      echo = 1'b1;
      step(100);
      #4 rst = 1'b1;
      #1;
      check("mrst_trig", 16'(trigger), 16'd0);
      check("mrst_done", 16'(done), 16'd0);
      check("mrst_dist", distance, 16'd0);
      #5 rst = 1'b0;
      echo = 1'b0;
      step(3);
      check("post_rst_done", 16'(done), 16'd0);
      do_start(16'd0, 1'b0);
      measure(2940, 0, 16'd10, "after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
